// File: rtl/memory_single_port.sv
// Single-port synchronous RAM with a shared address bus and a registered read port.
// Reset clears only the read register; stored words persist across reset.
module memory_single_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] data_0_in,
  output logic [DATA_WIDTH-1:0] data_0_out,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic                  oe_0
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  wr_en_p0;
  logic                  rd_en_p0;

  // Write wins over read when both are requested; a read never sees same-cycle write data.
  assign wr_en_p0 = reset & cs_0 & we_0;
  assign rd_en_p0 = reset & cs_0 & oe_0 & ~we_0;

  // Stage p0 -> array: storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      mem[address_0] <= data_0_in;
    end
  end

  // Stage p0 -> registered read data (holds when no read is issued).
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_0_out <= '0;
    end else if (rd_en_p0) begin
      data_0_out <= mem[address_0];
    end
  end

endmodule

// File: tb/tb_memory_single_port.sv
// Scoreboard bench for memory_single_port: a word-array reference model predicts
// data_0_out after every edge; a separate monitor compares on the falling edge.
module tb_memory_single_port;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address_0;
  logic [DW-1:0] data_0_in;
  logic [DW-1:0] data_0_out;
  logic          cs_0, we_0, oe_0;

  memory_single_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .address_0(address_0), .data_0_in(data_0_in),
    .data_0_out(data_0_out), .cs_0(cs_0), .we_0(we_0), .oe_0(oe_0)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays plus the value the output should show.
  logic [DW-1:0] model_mem [DEPTH];
  bit            written   [DEPTH];
  logic [DW-1:0] model_out;

  logic [DW-1:0] exp_q [$];
  int            errors = 0;
  int            checks = 0;

  // Monitor: one expected value per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [DW-1:0] exp_v;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_0_out !== exp_v) begin
        errors++;
        $display("FAIL data_0_out t=%0t got=%h expected=%h", $time, data_0_out, exp_v);
      end
    end
  end

  task automatic step(input logic r, input logic c, input logic w, input logic o,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    reset = r; cs_0 = c; we_0 = w; oe_0 = o; address_0 = a; data_0_in = d;
    @(posedge clk);
    if (!r) begin
      model_out = '0;
    end else if (c && w) begin
      model_mem[a] = d;
      written[a] = 1'b1;
    end else if (c && o) begin
      model_out = model_mem[a];
    end
    exp_q.push_back(model_out);
    #1;
  endtask

  initial begin
    model_out = '0;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

    // 1: reset, then idle with cs high and no enables
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'(i), 32'hFFFF_FFFF);

    // 2: fill 0..127 with their own address, then read back
    for (int i = 0; i < 128; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'(i), DW'(i));
    for (int i = 0; i < 128; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'(i), 32'h0);

    // 3: boundary addresses
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1234_5678);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0);

    // 4: deselected write is ignored, output holds
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 32'hAAAA_5555);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 32'h0);

    // 5: write takes priority over read
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'd9, 32'h77);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd9, 32'h0);

    // 6: mid-stream reset clears the output only
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd10, 32'hBAD0_BAD0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd10, 32'h0);

    // Random traffic; reads are steered to addresses that hold defined data
    for (int n = 0; n < 600; n++) begin
      logic r, c, w, o;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      r = ($urandom_range(0, 39) != 0);
      c = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      o = $urandom_range(0, 1);
      a = AW'($urandom);
      d = $urandom;
      if (r && c && !w && o && !written[a]) a = AW'($urandom_range(0, 127));
      step(r, c, w, o, a, d);
    end

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        errors++;
        checks++;
        $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
